// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame sequencer.
// Holds the sequencer state encoding and index-width helper.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_CREDIT = 2'd1,
    STREAM      = 2'd2
  } seq_state_t;

  // Credit counter width; covers MaxOutstanding up to 15.
  localparam int CREDIT_W = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_credit_counter.sv
// Frames-in-flight counter for the FFT core.
// take = frame handed to the core, give = frame retired at its source.
module fft_credit_counter
  import fft_pkg::*;
#(
  parameter int MaxOutstanding = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                take,
  input  logic                give,
  output logic [CREDIT_W-1:0] outstanding,
  output logic                avail
);

  localparam logic [CREDIT_W:0] MAX_C = MaxOutstanding[CREDIT_W:0];

  logic give_eff;
  logic take_eff;

  // A retire with nothing in flight is spurious and dropped.
  assign give_eff = give && (outstanding != '0);
  assign take_eff = take &&
                    (({1'b0, outstanding} < MAX_C) || give_eff);
  assign avail    = {1'b0, outstanding} < MAX_C;

  // Net credit change; simultaneous take and give cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else if (take_eff && !give_eff) begin
      outstanding <= outstanding + 1'b1;
    end else if (give_eff && !take_eff) begin
      outstanding <= outstanding - 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames a sample stream into NSamples-long FFT frames, credit-limited.
// Optional FFT_SEQ_STATS_EN adds stall/starve cycle counters.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int W              = 16,
  parameter int NSamples       = 1024,
  parameter int MaxOutstanding = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] fft_sink_data,
  output logic         fft_sink_valid,
  input  logic         fft_sink_ready,
  output logic         fft_sink_sop,
  output logic         fft_sink_eop,
  input  logic         fft_source_eop,
  output logic         busy,
  output logic [15:0]  frame_count
`ifdef FFT_SEQ_STATS_EN
  ,
  output logic [31:0]  stall_cycles,
  output logic [31:0]  starve_cycles
`endif
);

  localparam int IW = idx_w(NSamples);
  localparam logic [IW-1:0] LAST = IW'(NSamples - 1);
  localparam logic [CREDIT_W:0] MAX_C = MaxOutstanding[CREDIT_W:0];

  seq_state_t          state;
  logic [IW-1:0]       idx;
  logic [CREDIT_W-1:0] outstanding;
  logic                avail;
  logic                in_stream;
  logic                xfer;
  logic                eop_xfer;
  logic                retire;
  logic [CREDIT_W:0]   occ_after;
  logic                room_after;

  assign in_stream      = (state == STREAM);
  assign fft_sink_data  = in_data;
  assign fft_sink_valid = in_valid && in_stream;
  assign in_ready       = fft_sink_ready && in_stream;
  assign xfer           = in_valid && in_ready;
  assign fft_sink_sop   = fft_sink_valid && (idx == '0);
  assign fft_sink_eop   = fft_sink_valid && (idx == LAST);
  assign eop_xfer       = xfer && (idx == LAST);
  assign busy           = (state != IDLE);

  // Occupancy after this frame's eop, counting a retire in the same
  // cycle, so a returning credit keeps frames back-to-back.
  assign retire     = fft_source_eop && (outstanding != '0);
  assign occ_after  = {1'b0, outstanding} + 1'b1
                    - {{CREDIT_W{1'b0}}, retire};
  assign room_after = occ_after < MAX_C;

  fft_credit_counter #(
    .MaxOutstanding(MaxOutstanding)
  ) u_credit (
    .clk        (clk),
    .reset      (reset),
    .take       (eop_xfer),
    .give       (fft_source_eop),
    .outstanding(outstanding),
    .avail      (avail)
  );

  // Sequencer: frames only start or stop at frame boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (enable && avail)
            state <= STREAM;
          else if (enable)
            state <= WAIT_CREDIT;
        end
        (state == WAIT_CREDIT): begin
          if (!enable)
            state <= IDLE;
          else if (avail)
            state <= STREAM;
        end
        (state == STREAM): begin
          if (eop_xfer) begin
            if (enable && room_after)
              state <= STREAM;
            else if (enable)
              state <= WAIT_CREDIT;
            else
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sample index within the current frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idx <= '0;
    else if (xfer)
      idx <= (idx == LAST) ? '0 : idx + 1'b1;
  end

  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frame_count <= '0;
    else if (eop_xfer)
      frame_count <= frame_count + 16'd1;
  end

`ifdef FFT_SEQ_STATS_EN
  // Saturating stall and starve cycle counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles  <= '0;
      starve_cycles <= '0;
    end else begin
      if (state == WAIT_CREDIT && in_valid && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (in_stream && !in_valid && starve_cycles != '1)
        starve_cycles <= starve_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer (NSamples=8, Max=2).
// Frame-level model plus directed literal checks.
module tb_fft_frame_sequencer;

  localparam int W   = 16;
  localparam int N   = 8;
  localparam int MAX = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] fft_sink_data;
  logic         fft_sink_valid;
  logic         fft_sink_ready;
  logic         fft_sink_sop;
  logic         fft_sink_eop;
  logic         fft_source_eop;
  logic         busy;
  logic [15:0]  frame_count;

  fft_frame_sequencer #(
    .W(W), .NSamples(N), .MaxOutstanding(MAX)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .fft_sink_data (fft_sink_data),
    .fft_sink_valid(fft_sink_valid),
    .fft_sink_ready(fft_sink_ready),
    .fft_sink_sop  (fft_sink_sop),
    .fft_sink_eop  (fft_sink_eop),
    .fft_source_eop(fft_source_eop),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Frame-level model: run = permitted to pass samples,
  // pos = samples of current frame sent, cred = frames in flight.
  bit m_run, m_busy;
  int m_pos, m_cred, m_sent, m_frames, m_fc, cyc;
  int m_ce;
  bit m_ge, m_x;
  bit auto_ret = 0;
  int due_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_busy = 0; m_pos = 0;
      m_cred = 0; m_sent = 0; m_fc = 0;
    end else begin
      cyc++;
      m_ge = fft_source_eop && (m_cred > 0);
      m_x  = m_run && in_valid && fft_sink_ready;
      if (m_x) begin
        m_sent++;
        if (m_pos == N - 1) begin
          m_ce = m_cred + 1 - int'(m_ge);
          m_frames++;
          m_fc = (m_fc + 1) % 65536;
          m_run = enable && (m_ce < MAX);
          m_busy = enable;
          m_pos = 0;
          m_cred = m_ce;
          if (auto_ret) due_q.push_back(cyc + 30);
        end else begin
          m_pos++;
          m_cred -= int'(m_ge);
        end
      end else begin
        if (!m_run) begin
          m_run = enable && (m_cred < MAX);
          m_busy = enable;
        end
        m_cred -= int'(m_ge);
      end
    end
  end

  // Source-eop responder: manual toggles or delayed auto returns.
  bit man_tgl = 0;
  bit seen_tgl = 0;
  int due_rd = 0;
  initial begin
    fft_source_eop = 0;
    forever begin
      @(posedge clk);
      #2;
      if (man_tgl != seen_tgl) begin
        seen_tgl = man_tgl;
        fft_source_eop = 1;
      end else if (due_rd < due_q.size() && due_q[due_rd] <= cyc) begin
        due_rd++;
        fft_source_eop = 1;
      end else begin
        fft_source_eop = 0;
      end
    end
  end

  // Per-cycle compare against the model, plus xfer bookkeeping.
  int n_x = 0;
  int max_out = 0;
  bit [63:0] sop_m = '0;
  bit [63:0] eop_m = '0;
  always @(negedge clk) begin
    chk("valid", fft_sink_valid, m_run && in_valid);
    chk("in_ready", in_ready, m_run && fft_sink_ready);
    chk("sop", fft_sink_sop, m_run && in_valid && m_pos == 0);
    chk("eop", fft_sink_eop, m_run && in_valid && m_pos == N - 1);
    chk("busy", busy, m_busy || m_run);
    chk("frame_count", frame_count, m_fc);
    if (m_run && in_valid)
      chk("data", fft_sink_data, m_sent[W-1:0]);
    if (int'(dut.u_credit.outstanding) > max_out)
      max_out = int'(dut.u_credit.outstanding);
    if (fft_sink_valid && in_ready) begin
      if (n_x < 64) begin
        sop_m[n_x] = fft_sink_sop;
        eop_m[n_x] = fft_sink_eop;
      end
      n_x++;
    end
  end

  bit rnd = 0;
  task automatic step();
    @(posedge clk);
    #1;
    in_data = m_sent[W-1:0];
    if (rnd) begin
      in_valid       = 1'($urandom_range(0, 1));
      fft_sink_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pulse_reset();
    step();
    reset = 1;
    step();
    reset = 0;
  endtask

  int base;
  bit found;

  initial begin
    reset = 1; enable = 0; in_valid = 0;
    fft_sink_ready = 0; in_data = '0;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", frame_count, 0);
    reset = 0;

    // 1: free-running until credits run out
    enable = 1; in_valid = 1; fft_sink_ready = 1;
    repeat (40) step();
    chk("t1_xfers", n_x, 16);
    chk("t1_sop_pos", sop_m[15:0], 32'h0101);
    chk("t1_eop_pos", eop_m[15:0], 32'h8080);
    chk("t1_fc", frame_count, 2);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_busy", busy, 1);
    chk("t1_out", dut.u_credit.outstanding, 2);

    // 2: one credit back releases exactly one frame
    man_tgl = ~man_tgl;
    repeat (25) step();
    chk("t2_xfers", n_x, 24);
    chk("t2_sop16", sop_m[16], 1);
    chk("t2_fc", frame_count, 3);
    chk("t2_in_ready", in_ready, 0);

    // 3: stop mid-frame finishes the frame
    pulse_reset();
    base = n_x;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      step();
      found = (m_pos == 3);
    end
    if (!found) timeout("t3_wait_idx3");
    enable = 0;
    repeat (20) step();
    chk("t3_xfers", n_x - base, 8);
    chk("t3_fc", frame_count, 1);
    chk("t3_busy", busy, 0);
    chk("t3_in_ready", in_ready, 0);

    // 4: random handshakes, credits returned 30 cycles after eop
    pulse_reset();
    due_rd = due_q.size();
    auto_ret = 1; rnd = 1; enable = 1;
    found = 0;
    for (int k = 0; k < 6000 && !found; k++) begin
      step();
      found = (m_fc == 20);
    end
    if (!found) timeout("t4_wait_20_frames");
    chk("t4_fc", frame_count, 20);
    enable = 0;
    chk("t4_max_out_le2", max_out <= MAX, 1);
    rnd = 0; in_valid = 1; fft_sink_ready = 1;
    repeat (150) step();
    auto_ret = 0;

    // 5: eop and retire in the same cycle at one credit
    pulse_reset();
    due_rd = due_q.size();
    enable = 1;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      step();
      found = (m_fc == 1 && m_pos == 7);
    end
    if (!found) timeout("t5_wait_eop");
    man_tgl = ~man_tgl;
    step();
    chk("t5_out", dut.u_credit.outstanding, 1);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_fc", frame_count, 2);
    chk("t5_sop", fft_sink_sop, 1);

    // 6: reset mid-frame clears outputs at once
    pulse_reset();
    enable = 1;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      step();
      found = (m_pos == 5);
    end
    if (!found) timeout("t6_wait_idx5");
    chk("t6_pre_valid", fft_sink_valid, 1);
    #1 reset = 1;
    #1;
    chk("t6_rst_valid", fft_sink_valid, 0);
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_eop", fft_sink_eop, 0);
    chk("t6_rst_idx", dut.idx, 0);
    @(negedge clk);
    #2 reset = 0;
    step();
    chk("t6_sop", fft_sink_sop, 1);
    chk("t6_valid", fft_sink_valid, 1);
    chk("t6_idx", dut.idx, 0);
    repeat (5) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
